// File: rtl/intensity_recombine_kernel.sv
// Recombines sharpened intensity with the original RGB by applying delta = Y' - Y per channel.
// 4-stage pipeline with a global stall enable; tracks line/frame geometry on output handshakes.
module intensity_recombine_kernel #(
  parameter int PXL_D_WIDTH = 8,
  parameter int HORZ_SIZE   = 1280,
  parameter int VERT_SIZE   = 720
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PXL_D_WIDTH*4-1:0] s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tuser,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic [PXL_D_WIDTH*3-1:0] m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tuser,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic [9:0]               line_cnt,
  output logic [15:0]              frame_cnt,
  output logic                     geom_err
);

  localparam int W  = PXL_D_WIDTH;
  localparam int PW = W + 8;
  localparam int CW = (HORZ_SIZE > 1) ? $clog2(HORZ_SIZE) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(HORZ_SIZE - 1);
  localparam logic [9:0]    LINE_LAST = 10'(VERT_SIZE - 1);
  localparam logic [W-1:0]  PXL_MAX   = '1;

  logic en;

  logic         s1_vld, s1_user, s1_last;
  logic [W-1:0] s1_r, s1_g, s1_b, s1_yp;

  logic          s2_vld, s2_user, s2_last;
  logic [PW-1:0] s2_pr, s2_pg, s2_pb;
  logic [W-1:0]  s2_r, s2_g, s2_b, s2_yp;

  logic              s3_vld, s3_user, s3_last;
  logic [W-1:0]      s3_r, s3_g, s3_b;
  logic signed [W:0] s3_delta;

  logic           s4_vld, s4_user, s4_last;
  logic [3*W-1:0] s4_dat;

  logic [PW-1:0]     y_sum;
  logic [W-1:0]      y_old;
  logic signed [W:0] delta;

  logic          out_fire, col_is_last, sof_err, sof_seen;
  logic [CW-1:0] col_cnt;
  logic [9:0]    line_base, line_nxt;

  // Coefficients sum to 256, so the weighted sum never exceeds W+8 bits.
  assign y_sum = s2_pr + s2_pg + s2_pb;
  assign y_old = y_sum[PW-1:8];
  assign delta = $signed({1'b0, s2_yp}) - $signed({1'b0, y_old});

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] c, input logic signed [W:0] d);
    logic signed [W+1:0] s;
    s = $signed({2'b00, c}) + $signed({d[W], d});
    if (s[W+1])  return '0;
    else if (s[W]) return PXL_MAX;
    else           return s[W-1:0];
  endfunction

  assign en            = ~s4_vld | m_axis_tready;
  assign s_axis_tready = en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld <= 1'b0; s1_user <= 1'b0; s1_last <= 1'b0;
      s1_r <= '0; s1_g <= '0; s1_b <= '0; s1_yp <= '0;
      s2_vld <= 1'b0; s2_user <= 1'b0; s2_last <= 1'b0;
      s2_pr <= '0; s2_pg <= '0; s2_pb <= '0;
      s2_r <= '0; s2_g <= '0; s2_b <= '0; s2_yp <= '0;
      s3_vld <= 1'b0; s3_user <= 1'b0; s3_last <= 1'b0;
      s3_r <= '0; s3_g <= '0; s3_b <= '0; s3_delta <= '0;
      s4_vld <= 1'b0; s4_user <= 1'b0; s4_last <= 1'b0; s4_dat <= '0;
    end else if (en) begin
      s1_vld <= s_axis_tvalid;
      if (s_axis_tvalid) begin
        s1_r    <= s_axis_tdata[4*W-1:3*W];
        s1_g    <= s_axis_tdata[3*W-1:2*W];
        s1_b    <= s_axis_tdata[2*W-1:W];
        s1_yp   <= s_axis_tdata[W-1:0];
        s1_user <= s_axis_tuser;
        s1_last <= s_axis_tlast;
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_pr   <= PW'(s1_r) * PW'(77);
        s2_pg   <= PW'(s1_g) * PW'(151);
        s2_pb   <= PW'(s1_b) * PW'(28);
        s2_r    <= s1_r;  s2_g <= s1_g;  s2_b <= s1_b;  s2_yp <= s1_yp;
        s2_user <= s1_user;
        s2_last <= s1_last;
      end
      s3_vld <= s2_vld;
      if (s2_vld) begin
        s3_r     <= s2_r;  s3_g <= s2_g;  s3_b <= s2_b;
        s3_delta <= delta;
        s3_user  <= s2_user;
        s3_last  <= s2_last;
      end
      // Output registers only load on valid beats so a bubble leaves the last pixel visible.
      s4_vld <= s3_vld;
      if (s3_vld) begin
        s4_dat  <= {sat_add(s3_r, s3_delta), sat_add(s3_g, s3_delta), sat_add(s3_b, s3_delta)};
        s4_user <= s3_user;
        s4_last <= s3_last;
      end
    end
  end

  assign m_axis_tvalid = s4_vld;
  assign m_axis_tdata  = s4_dat;
  assign m_axis_tuser  = s4_user;
  assign m_axis_tlast  = s4_last;

  assign out_fire    = s4_vld & m_axis_tready;
  assign col_is_last = (col_cnt == COL_LAST);
  assign sof_err     = s4_user & sof_seen & ((col_cnt != '0) | (line_cnt != '0));

  // A start-of-frame restarts the line count before this beat's own tlast is applied.
  always_comb begin
    line_base = s4_user ? '0 : line_cnt;
    line_nxt  = line_base;
    if (s4_last) line_nxt = (line_base == LINE_LAST) ? '0 : line_base + 10'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_cnt   <= '0;
      line_cnt  <= '0;
      frame_cnt <= '0;
      geom_err  <= 1'b0;
      sof_seen  <= 1'b0;
    end else if (out_fire) begin
      col_cnt  <= s4_last ? '0 : col_cnt + CW'(1);
      line_cnt <= line_nxt;
      if (s4_user) begin
        frame_cnt <= frame_cnt + 16'd1;
        sof_seen  <= 1'b1;
      end
      if ((s4_last != col_is_last) | sof_err) geom_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_intensity_recombine_kernel.sv
// Directed and random checks of intensity_recombine_kernel with a small 4x3 frame geometry.
module tb_intensity_recombine_kernel;
  localparam int HS = 4;
  localparam int VS = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tuser, s_tlast, s_tready;
  logic [23:0] m_tdata;
  logic        m_tvalid, m_tuser, m_tlast, m_tready;
  logic [9:0]  line_cnt;
  logic [15:0] frame_cnt;
  logic        geom_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  intensity_recombine_kernel #(.PXL_D_WIDTH(8), .HORZ_SIZE(HS), .VERT_SIZE(VS)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tuser(s_tuser),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tuser(m_tuser),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .line_cnt(line_cnt), .frame_cnt(frame_cnt), .geom_err(geom_err)
  );

  function automatic logic [23:0] ref_rgb(input logic [31:0] d);
    int y, v;
    logic [23:0] res;
    y = (int'(d[31:24]) * 77 + int'(d[23:16]) * 151 + int'(d[15:8]) * 28) / 256;
    res = '0;
    for (int i = 0; i < 3; i++) begin
      v = int'(d[31-8*i -: 8]) + int'(d[7:0]) - y;
      if (v < 0) v = 0;
      else if (v > 255) v = 255;
      res[23-8*i -: 8] = 8'(v);
    end
    return res;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    end
  endtask

  task automatic send_line(input int n, input logic sof);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_tvalid = 1'b1; s_tdata = $urandom;
      s_tuser = sof && (i == 0);
      s_tlast = (i == n - 1);
    end
    @(negedge clk);
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({m_tvalid, m_tuser, m_tlast, m_tdata, line_cnt, frame_cnt, geom_err} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got vld=%b usr=%b lst=%b dat=%h line=%0d frame=%0d err=%b exp all zero",
               m_tvalid, m_tuser, m_tlast, m_tdata, line_cnt, frame_cnt, geom_err);
    end
    n_cmp++;
    if (s_tready !== 1'b1) begin n_err++; $display("FAIL reset_tready got=%b exp=1", s_tready); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    m_tready = 1'b1; s_tvalid = 1'b1; s_tuser = 1'b1; s_tlast = 1'b1;
    s_tdata = {8'd100, 8'd150, 8'd200, 8'd160};
    #1;
    n_cmp++;
    if (s_tready !== 1'b1) begin n_err++; $display("FAIL single_accept got=%b exp=1", s_tready); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
      #1;
      n_cmp++;
      if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL single_early cycle=%0d got=%b exp=0", i, m_tvalid); end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({m_tvalid, m_tuser, m_tlast, m_tdata} !== {3'b111, 8'd120, 8'd170, 8'd220}) begin
      n_err++;
      $display("FAIL single_beat got vld=%b usr=%b lst=%b dat=%h exp vld=1 usr=1 lst=1 dat=78aadc",
               m_tvalid, m_tuser, m_tlast, m_tdata);
    end
    idle(4);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    m_tready = 1'b1; s_tvalid = 1'b1; s_tdata = {8'd250, 8'd250, 8'd250, 8'd255};
    @(negedge clk);
    s_tdata = {8'd10, 8'd200, 8'd10, 8'd0};
    @(negedge clk);
    s_tvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if ({m_tvalid, m_tdata} !== {1'b1, 24'hffffff}) begin
      n_err++; $display("FAIL clamp_high got vld=%b dat=%h exp vld=1 dat=ffffff", m_tvalid, m_tdata);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({m_tvalid, m_tdata} !== {1'b1, 8'd0, 8'd78, 8'd0}) begin
      n_err++; $display("FAIL clamp_low got vld=%b dat=%h exp vld=1 dat=004e00", m_tvalid, m_tdata);
    end
    idle(4);
  endtask

  task automatic test_backpressure();
    logic [23:0] q[$];
    logic [23:0] prev_dat, exp_dat;
    logic [3:0]  pat;
    logic        prev_stall;
    int sent, got;
    pat = 4'b1001; prev_stall = 1'b0; prev_dat = '0; sent = 0; got = 0;
    for (int c = 0; c < 200 && got < 12; c++) begin
      @(negedge clk);
      m_tready = pat[c % 4];
      s_tuser = 1'b0; s_tlast = 1'b0;
      s_tvalid = (sent < 12);
      s_tdata = {8'(sent * 20), 8'(255 - sent * 9), 8'(sent * 13 + 5), 8'(sent * 31)};
      #1;
      if (prev_stall) begin
        n_cmp++;
        if ({m_tvalid, m_tdata} !== {1'b1, prev_dat}) begin
          n_err++; $display("FAIL bp_hold cycle=%0d got vld=%b dat=%h exp vld=1 dat=%h", c, m_tvalid, m_tdata, prev_dat);
        end
      end
      n_cmp++;
      if (s_tready !== !(m_tvalid && !m_tready)) begin
        n_err++; $display("FAIL bp_tready cycle=%0d got=%b exp=%b", c, s_tready, !(m_tvalid && !m_tready));
      end
      if (m_tvalid && m_tready) begin
        exp_dat = (q.size() > 0) ? q.pop_front() : 24'hx;
        n_cmp++;
        if (m_tdata !== exp_dat) begin
          n_err++; $display("FAIL bp_data beat=%0d got=%h exp=%h", got, m_tdata, exp_dat);
        end
        got++;
      end
      if (s_tvalid && s_tready) begin q.push_back(ref_rgb(s_tdata)); sent++; end
      prev_stall = m_tvalid && !m_tready;
      prev_dat = m_tdata;
    end
    n_cmp++;
    if (got !== 12 || q.size() !== 0) begin
      n_err++; $display("FAIL bp_count got=%0d left=%0d exp got=12 left=0", got, q.size());
    end
    m_tready = 1'b1;
    idle(4);
  endtask

  task automatic test_geometry();
    pulse_reset();
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < VS; l++) begin
        send_line(HS, l == 0);
        if (f == 1 && l == 0) begin
          idle(6);
          #1;
          n_cmp++;
          if ({frame_cnt, line_cnt} !== {16'd2, 10'd1}) begin
            n_err++; $display("FAIL geom_sof2 got frame=%0d line=%0d exp frame=2 line=1", frame_cnt, line_cnt);
          end
        end
      end
      idle(6);
      #1;
      n_cmp++;
      if ({frame_cnt, line_cnt, geom_err} !== {16'(f + 1), 10'd0, 1'b0}) begin
        n_err++; $display("FAIL geom_frame%0d got frame=%0d line=%0d err=%b exp frame=%0d line=0 err=0",
                          f, frame_cnt, line_cnt, geom_err, f + 1);
      end
    end
    send_line(HS - 1, 1'b0);
    idle(6);
    #1;
    n_cmp++;
    if ({geom_err, line_cnt} !== {1'b1, 10'd1}) begin
      n_err++; $display("FAIL geom_short got err=%b line=%0d exp err=1 line=1", geom_err, line_cnt);
    end
    send_line(HS, 1'b0);
    idle(6);
    #1;
    n_cmp++;
    if ({geom_err, line_cnt} !== {1'b1, 10'd2}) begin
      n_err++; $display("FAIL geom_sticky got err=%b line=%0d exp err=1 line=2", geom_err, line_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_tvalid = 1'b1; s_tdata = $urandom; s_tuser = (i == 0); s_tlast = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0; s_tvalid = 1'b0; s_tuser = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL midrst_vld got=%b exp=0", m_tvalid); end
    n_cmp++;
    if ({line_cnt, frame_cnt, geom_err} !== '0) begin
      n_err++; $display("FAIL midrst_cnt got line=%0d frame=%0d err=%b exp all zero", line_cnt, frame_cnt, geom_err);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (m_tvalid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_err++; $display("FAIL midrst_stale got=%0d beats exp=0", seen); end
  endtask

  task automatic test_random();
    localparam int N = 10000;
    logic [25:0] q[$];
    logic [25:0] exp_b;
    int sent, got, c;
    bit fired;
    sent = 0; got = 0; c = 0; fired = 1'b1;
    pulse_reset();
    while (got < N && c < 60000) begin
      @(negedge clk);
      if (fired || !s_tvalid) begin
        if (sent < N && ($urandom % 10) < 7) begin
          s_tvalid = 1'b1; s_tdata = $urandom;
          s_tuser = (($urandom % 50) == 0);
          s_tlast = (($urandom % 8) == 0);
        end else begin
          s_tvalid = 1'b0;
        end
      end
      m_tready = (($urandom % 10) < 7);
      #1;
      if (m_tvalid && m_tready) begin
        exp_b = (q.size() > 0) ? q.pop_front() : 26'hx;
        n_cmp++;
        if ({m_tuser, m_tlast, m_tdata} !== exp_b) begin
          n_err++; $display("FAIL rand_beat idx=%0d got=%h exp=%h", got, {m_tuser, m_tlast, m_tdata}, exp_b);
        end
        got++;
      end
      if (s_tvalid && s_tready) begin
        q.push_back({s_tuser, s_tlast, ref_rgb(s_tdata)});
        sent++;
        fired = 1'b1;
      end else begin
        fired = 1'b0;
      end
      c++;
    end
    n_cmp++;
    if (got !== N || q.size() !== 0) begin
      n_err++; $display("FAIL rand_count got=%0d left=%0d exp got=%0d left=0", got, q.size(), N);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_geometry();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/intensity_recombine_kernel.md
Name: intensity_recombine_kernel

Overview:
- AXI4-Stream block that turns a processed intensity stream back into colour.
- Consumes beats of {original RGB, sharpened intensity} and recomputes the original intensity Y with the fixed luma coefficients (77,151,28, >>8).
- Applies delta = Y' − Y to each RGB channel with saturation and emits a 24-bit RGB video stream.
- Sits after the sharpening filter. Unlike the upstream intensity kernel, it implements full valid/ready backpressure and tracks line and frame geometry.

Parameters:
- PXL_D_WIDTH, 8, bits per colour channel and per intensity sample.
- HORZ_SIZE, 1280, pixels per line; used for line-length checking.
- VERT_SIZE, 720, lines per frame; used for the line counter wrap and the frame-length check.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- s_axis_tdata  input  PXL_D_WIDTH*4  bits [31:24]=R, [23:16]=G, [15:8]=B, [7:0]=sharpened intensity Y'.
- s_axis_tvalid  input  1  input beat valid.
- s_axis_tuser  input  1  start of frame, on the first pixel.
- s_axis_tlast  input  1  end of line.
- s_axis_tready  output  1  block accepts a beat.
- m_axis_tdata  output  PXL_D_WIDTH*3  {R',G',B'}.
- m_axis_tvalid  output  1  output beat valid.
- m_axis_tuser  output  1  start of frame, delayed with its pixel.
- m_axis_tlast  output  1  end of line, delayed with its pixel.
- m_axis_tready  input  1  downstream ready.
- line_cnt  output  10  lines emitted in the current frame.
- frame_cnt  output  16  frames emitted since reset.
- geom_err  output  1  sticky line/frame geometry error.

Behaviour:
- Reset: synchronous and active-low; evaluated only on the clk rising edge. While rst_n=0 at an edge, the following are cleared: all stage valids, data, tuser, tlast, col_cnt, line_cnt, frame_cnt and geom_err. After reset, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, line_cnt=0, frame_cnt=0, geom_err=0. Reset asserted mid-frame discards all in-flight beats; no partial output follows.
- Pipeline: 4 register stages with a global enable en = ~S4_valid | m_axis_tready, and s_axis_tready = en.
  - An input beat is accepted when s_axis_tvalid & s_axis_tready.
  - A beat accepted at edge k is presented on m_axis from edge k+3, so latency is 4 cycles with no stall.
  - When en=0, every stage holds its contents. m_axis_tdata, tuser and tlast stay stable while m_axis_tvalid=1 and m_axis_tready=0.
  - Bubbles (stage valid=0) propagate normally. The data of invalid stages is don't-care, but the output is held at its last value.
- Stage functions:
  - S1: register the inputs.
  - S2: products pr=R*77, pg=G*151, pb=B*28, each 16 bits unsigned.
  - S3: Y = (pr+pg+pb)>>8. The maximum sum is 65280, so no overflow occurs. delta = Y' − Y as 9-bit signed, range −255..255.
  - S4: each channel c' = clamp(c + delta, 0, 255), computed in 10-bit signed arithmetic.
- tuser and tlast travel with their pixel unchanged.
- Geometry tracking, on output handshakes (m_axis_tvalid & m_axis_tready):
  - col_cnt increments on every handshake and clears on a handshake with tlast.
  - line_cnt increments on a tlast handshake and wraps to 0 after VERT_SIZE−1.
  - A tuser handshake sets frame_cnt+1 and line_cnt=0. frame_cnt wraps at 2^16.
- geom_err is set (sticky until reset) on any of:
  - tlast handshake with col_cnt ≠ HORZ_SIZE−1;
  - a non-tlast handshake with col_cnt = HORZ_SIZE−1;
  - tuser on a beat with col_cnt ≠ 0;
  - tuser while line_cnt ≠ 0.
  The first tuser after reset never flags. The counters keep counting regardless of geom_err.
- Simultaneous tuser and tlast on one beat (1-pixel line, HORZ_SIZE=1): frame_cnt increments and line_cnt becomes 1.

Test Plan:
- Unstalled single beat R,G,B,Y'=100,150,200,160 (Y=140, delta=+20) → m_axis_tdata = {120,170,220} with m_axis_tvalid exactly 4 cycles after acceptance.
- Clamp high: 250,250,250,Y'=255 (Y=250) → {255,255,255}. Clamp low: 10,200,10,Y'=0 (Y=122) → {0,78,0}.
- Backpressure: continuous input with m_axis_tready toggling 1,0,0,1 → no beat dropped or duplicated; tdata stable while stalled; s_axis_tready=0 exactly when S4 is full and m_axis_tready=0.
- Frame geometry, HORZ_SIZE=4, VERT_SIZE=3: two correct frames → frame_cnt=2, line_cnt=0 after second tuser, geom_err=0. A line of 3 beats with tlast → geom_err=1 and stays 1.
- Reset mid-frame with 3 beats in flight → m_axis_tvalid=0 next cycle, counters 0, no stale beats emitted after release.
- Random streaming, 10k beats with random valid/ready, compared to a reference model → bit-exact RGB and sideband order.
